// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the multiply sequencer: ALU select codes and FSM state encoding.
package alu_mul_seq_pkg;

  localparam logic [2:0] AluSelAdd  = 3'd0;
  localparam logic [2:0] AluSelAnd  = 3'd1;
  localparam logic [2:0] AluSelXor  = 3'd2;
  localparam logic [2:0] AluSelSll  = 3'd3;
  localparam logic [2:0] AluSelSra  = 3'd4;
  localparam logic [2:0] AluSelSub  = 3'd5;
  localparam logic [2:0] AluSelJalr = 3'd6;
  localparam logic [2:0] AluSelZero = 3'd7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAdd   = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared ALU for its ADD and SLL steps.
// Produces the low WIDTH bits of op_a*op_b; the multiplier is shifted internally.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter logic [2:0]  SEL_ADD  = AluSelAdd,
  parameter logic [2:0]  SEL_SLL  = AluSelSll,
  parameter logic [2:0]  SEL_ZERO = AluSelZero
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic             alu_req,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_sal
);

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] w_mplier_shr;

  assign w_mplier_shr = r_mplier >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            if (op_b == '0) begin
              r_state <= StDone;
            end else if (op_b[0]) begin
              r_state <= StAdd;
            end else begin
              r_state <= StShift;
            end
          end
        end
        StAdd: begin
          r_acc   <= alu_sal;
          r_state <= StShift;
        end
        StShift: begin
          r_mcand  <= alu_sal;
          r_mplier <= w_mplier_shr;
          // Bit 1 of the current multiplier becomes bit 0 after this shift.
          if (w_mplier_shr == '0) begin
            r_state <= StDone;
          end else if (r_mplier[1]) begin
            r_state <= StAdd;
          end else begin
            r_state <= StShift;
          end
        end
        StDone: begin
          r_prod  <= r_acc;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    alu_req = 1'b0;
    alu_rs1 = '0;
    alu_rs2 = '0;
    alu_sel = SEL_ZERO;
    prod    = r_prod;
    unique case (r_state)
      StIdle: ;
      StAdd: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        alu_rs1 = r_acc;
        alu_rs2 = r_mcand;
        alu_sel = SEL_ADD;
      end
      StShift: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        alu_rs1 = r_mcand;
        alu_rs2 = WIDTH'(1);
        alu_sel = SEL_SLL;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
        // Bypass so the result is visible in the same cycle as the done pulse.
        prod = r_acc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq with a behavioural stand-in for the shared ALU and a product scoreboard.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, alu_req;
  logic [31:0] prod, alu_rs1, alu_rs2, alu_sal;
  logic [2:0]  alu_sel;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  sel_trace[$];
  int          req_cycles;
  int          done_pulses;

  always #5 clk = ~clk;

  alu_mul_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .prod    (prod),
    .alu_req (alu_req),
    .alu_rs1 (alu_rs1),
    .alu_rs2 (alu_rs2),
    .alu_sel (alu_sel),
    .alu_sal (alu_sal)
  );

  // Combinational shared ALU.
  always_comb begin
    alu_sal = '0;
    case (alu_sel)
      3'd0:    alu_sal = alu_rs1 + alu_rs2;
      3'd1:    alu_sal = alu_rs1 & alu_rs2;
      3'd2:    alu_sal = alu_rs1 ^ alu_rs2;
      3'd3:    alu_sal = alu_rs1 << alu_rs2[4:0];
      3'd4:    alu_sal = $signed(alu_rs1) >>> alu_rs2[4:0];
      3'd5:    alu_sal = alu_rs1 - alu_rs2;
      3'd6:    alu_sal = (alu_rs1 + alu_rs2) & ~32'd1;
      default: alu_sal = '0;
    endcase
  end

  // Cycles from accept edge to done: one ADD per set bit, one SHIFT per bit up to the MSB, plus DONE.
  function automatic int exp_lat(input logic [31:0] b);
    int ones = 0;
    int msb = -1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        ones++;
        msb = i;
      end
    end
    return (b == '0) ? 1 : ones + msb + 2;
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    p     = a * b;
    exp_q.push_back(p);
  endtask

  // Steps cycles after an accept until done; lat = -1 if the budget runs out.
  task automatic collect(input int budget, output int lat);
    lat = -1;
    sel_trace.delete();
    req_cycles  = 0;
    done_pulses = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (alu_req) begin
        req_cycles++;
        sel_trace.push_back(alu_sel);
      end
      if (done) begin
        done_pulses++;
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input int lat, input int want_lat);
    logic [31:0] want;
    n_checks++;
    if (lat !== want_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d, expected %0d", name, lat, want_lat);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue, expected one entry", name);
    end else begin
      want = exp_q.pop_front();
      if (prod !== want) begin
        n_fail++;
        $display("FAIL %s prod: got %h, expected %h", name, prod, want);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, done, alu_req} !== 3'b000 || prod !== '0 || alu_sel !== 3'd7 ||
        alu_rs1 !== '0 || alu_rs2 !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b req=%b prod=%h sel=%0d rs1=%h rs2=%h, expected 0,0,0,0,7,0,0",
               busy, done, alu_req, prod, alu_sel, alu_rs1, alu_rs2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [2:0] exp_sel [5] = '{3'd0, 3'd3, 3'd3, 3'd0, 3'd3};
    int lat;
    launch(32'd3, 32'd5);
    collect(100, lat);
    check_result("basic", lat, 6);
    n_checks++;
    if (sel_trace.size() != 5) begin
      n_fail++;
      $display("FAIL basic sel_trace_len: got %0d, expected 5", sel_trace.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (sel_trace[i] !== exp_sel[i]) begin
          n_fail++;
          $display("FAIL basic sel[%0d]: got %0d, expected %0d", i, sel_trace[i], exp_sel[i]);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || prod !== 32'd15) begin
      n_fail++;
      $display("FAIL basic hold_idle: got busy=%b prod=%h, expected 0 and 0000000f", busy, prod);
    end
  endtask

  task automatic test_zero();
    int lat;
    launch(32'h1234, 32'h0);
    collect(100, lat);
    check_result("zero", lat, 1);
    n_checks++;
    if (req_cycles != 0) begin
      n_fail++;
      $display("FAIL zero alu_req_cycles: got %0d, expected 0", req_cycles);
    end
  endtask

  task automatic test_wrap();
    int lat;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect(200, lat);
    check_result("wrap_all_ones", lat, exp_lat(32'hFFFF_FFFF));
    n_checks++;
    if (prod !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL wrap_all_ones const: got %h, expected 00000001", prod);
    end
    launch(32'd2, 32'h8000_0000);
    collect(200, lat);
    check_result("wrap_overflow", lat, exp_lat(32'h8000_0000));
  endtask

  task automatic test_start_busy();
    int lat;
    int extra = 0;
    launch(32'd6, 32'd7);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a  = 32'd9;
    op_b  = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(100, lat);
    if (lat > 0) lat += 3;
    check_result("start_busy", lat, exp_lat(32'd7));
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy extra_done: got %0d pulses busy=%b, expected 0 and 0", extra, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(32'd5, 32'd3);
    @(negedge clk);
    op_a = 32'd4;
    op_b = 32'd4;
    exp_q.push_back(32'd16);
    lat = -1;
    for (int c = 2; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    check_result("b2b_first", lat, exp_lat(32'd3));
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b idle_gap: got busy=%b, expected 0", busy);
    end
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    check_result("b2b_second", lat, exp_lat(32'd4));
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    launch(32'd7, 32'h0000_FFFF);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre_busy: got %b, expected 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0 || prod !== '0 || alu_sel !== 3'd7) begin
      n_fail++;
      $display("FAIL reset_mid async: got busy=%b done=%b req=%b prod=%h sel=%0d, expected 0,0,0,0,7",
               busy, done, alu_req, prod, alu_sel);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || alu_sel !== 3'd7 || prod !== '0) begin
      n_fail++;
      $display("FAIL reset_mid idle_after: got busy=%b sel=%0d prod=%h, expected 0,7,0",
               busy, alu_sel, prod);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom & ((32'd1 << $urandom_range(12, 1)) - 32'd1);
      launch(a, b);
      collect(100, lat);
      check_result("random", lat, exp_lat(b));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
